// File: rtl/cmd_tx_if.sv
// Command-link bus between the host-side controller and the command
// transmitter: request inputs plus the serial line and status outputs.
interface cmd_tx_if;
   logic       send_go;
   logic       send_stop;
   logic [5:0] dest_ID;
   logic       TX;
   logic       busy;
   logic       tx_done;
   logic       pending;
   logic [7:0] last_cmd;

   // Host side: issues requests, observes line and status.
   modport master (
      output send_go, send_stop, dest_ID,
      input  TX, busy, tx_done, pending, last_cmd
   );

   // Transmitter side: consumes requests, drives line and status.
   modport slave (
      input  send_go, send_stop, dest_ID,
      output TX, busy, tx_done, pending, last_cmd
   );
endinterface

// File: rtl/cmd_tx.sv
// Command transmitter: turns go/stop requests into command bytes and sends
// them as UART 8N1 frames (start 0, data LSB first, stop 1), BAUD_DIV clocks
// per bit. Requests arriving while a frame is on the line are held in a
// one-deep, latest-wins pending slot and launched with no idle gap.
module cmd_tx #(
   parameter int BAUD_DIV = 2604
) (
   input  logic     clk,
   input  logic     rst,
   cmd_tx_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XMIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [3:0]  BIT_LAST  = 4'd9;

   // Command encoding; stop takes priority over go.
   function automatic logic [7:0] encode_cmd(input logic stop, input logic [5:0] dest);
      logic [7:0] b;
      if (stop) begin
         b = 8'h00;
      end else begin
         b = {2'b01, dest};
      end
      return b;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pend_q, pend_d;
   logic [7:0]  pend_byte_q, pend_byte_d;
   logic [7:0]  last_q, last_d;

   logic        req_s;
   logic [7:0]  req_byte_s;
   logic        launch_s;
   logic [7:0]  launch_byte_s;

   assign req_s      = bus.send_go | bus.send_stop;
   assign req_byte_s = encode_cmd(bus.send_stop, bus.dest_ID);

   // Next-state and output logic; a launch loads the shifter and drives the
   // start bit from the following cycle.
   always_comb begin
      state_d       = state_q;
      baud_d        = baud_q;
      bit_d         = bit_q;
      shift_d       = shift_q;
      tx_d          = tx_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      pend_d        = pend_q;
      pend_byte_d   = pend_byte_q;
      last_d        = last_q;
      launch_s      = 1'b0;
      launch_byte_s = 8'h00;

      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               launch_s      = 1'b1;
               launch_byte_s = req_byte_s;
               state_d       = ST_XMIT;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_XMIT: begin
            // Any request on a busy line replaces the held one.
            if (req_s) begin
               pend_d      = 1'b1;
               pend_byte_d = req_byte_s;
            end else begin
               pend_d = pend_q;
            end

            if (baud_q == BAUD_LAST) begin
               baud_d = 16'd0;
               if (bit_q == BIT_LAST) begin
                  // Stop bit finished. The tx_done cycle becomes the first
                  // start-bit cycle of the next frame when something is
                  // waiting, so the launch is decided at this edge. A request
                  // in this very cycle is the latest one and wins.
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  if (req_s) begin
                     launch_s      = 1'b1;
                     launch_byte_s = req_byte_s;
                  end else if (pend_q) begin
                     launch_s      = 1'b1;
                     launch_byte_s = pend_byte_q;
                  end else begin
                     tx_d   = 1'b1;
                     busy_d = 1'b0;
                     bit_d  = 4'd0;
                  end
               end else begin
                  // Next bit: data bits come out LSB first; ones are shifted
                  // in behind them so the stop bit falls out naturally.
                  bit_d   = bit_q + 4'd1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b1, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end

         ST_DONE: begin
            if (busy_q) begin
               // Chained frame already started this cycle (baud count 0);
               // the held request is consumed, a new one takes its place.
               state_d = ST_XMIT;
               baud_d  = baud_q + 16'd1;
               pend_d  = req_s;
               if (req_s) begin
                  pend_byte_d = req_byte_s;
               end else begin
                  pend_byte_d = pend_byte_q;
               end
            end else if (req_s) begin
               // Nothing was pending: behave exactly like an idle request.
               launch_s      = 1'b1;
               launch_byte_s = req_byte_s;
               state_d       = ST_XMIT;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            baud_d  = 16'd0;
            bit_d   = 4'd0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            pend_d  = 1'b0;
         end
      endcase

      if (launch_s) begin
         tx_d    = 1'b0;
         busy_d  = 1'b1;
         shift_d = launch_byte_s;
         last_d  = launch_byte_s;
         baud_d  = 16'd0;
         bit_d   = 4'd0;
      end else begin
         last_d = last_q;
      end
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         baud_q      <= 16'd0;
         bit_q       <= 4'd0;
         shift_q     <= 8'h00;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_byte_q <= 8'h00;
         last_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pend_q      <= pend_d;
         pend_byte_q <= pend_byte_d;
         last_q      <= last_d;
      end
   end

   assign bus.TX       = tx_q;
   assign bus.busy     = busy_q;
   assign bus.tx_done  = done_q;
   assign bus.pending  = pend_q;
   assign bus.last_cmd = last_q;

endmodule

// File: tb/tb_cmd_tx.sv
// Bench for cmd_tx with BAUD_DIV=4: directed frame/priority/overwrite/
// back-to-back/reset scenarios, then randomized requests checked against a
// cycle-level request model and an independent UART decoder of the TX line.
module tb_cmd_tx;
   localparam int B = 4;

   logic clk;
   logic rst;
   cmd_tx_if bus ();

   cmd_tx #(.BAUD_DIV(B)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit logging     = 1'b0;
   int done_cnt    = 0;
   logic tx_log[$];

   // model state
   int         m_done = 0;
   bit         m_pv   = 1'b0;
   logic [7:0] m_pb   = 8'h00;
   logic [7:0] exp_q[$];
   logic [7:0] dec_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (logging) begin
         tx_log.push_back(bus.TX);
         if (bus.tx_done === 1'b1) done_cnt++;
      end
   endtask

   task automatic drive(input logic go, input logic stop, input logic [5:0] dest);
      bus.send_go   = go;
      bus.send_stop = stop;
      bus.dest_ID   = dest;
   endtask

   task automatic req(input logic go, input logic stop, input logic [5:0] dest);
      drive(go, stop, dest);
      tick();
      drive(1'b0, 1'b0, 6'h00);
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return b[j-1];
   endfunction

   // Checks the 40 cycles of one frame starting at the current cycle.
   task automatic check_frame(input logic [7:0] b, input logic first_done, input logic first_pend);
      for (int k = 0; k < 10*B; k++) begin
         chk("frame_tx", bus.TX, frame_bit(b, k / B));
         chk("frame_busy", bus.busy, 1'b1);
         chk("frame_done", bus.tx_done, (k == 0) ? first_done : 1'b0);
         chk("frame_pend", bus.pending, (k == 0) ? first_pend : 1'b0);
         if (k == 0) chk("last_cmd", bus.last_cmd, b);
         tick();
      end
   endtask

   // Request-level model: idle requests start next cycle, busy requests
   // overwrite a single held slot that chains into the tx_done cycle.
   task automatic model_step(input int t, input bit r, input logic [7:0] b);
      if (r) begin
         if (t >= m_done) begin
            exp_q.push_back(b);
            m_done = t + 1 + 10*B;
         end else begin
            m_pv = 1'b1;
            m_pb = b;
         end
      end
      if (m_pv && t == m_done - 1) begin
         exp_q.push_back(m_pb);
         m_done = m_done + 10*B;
         m_pv   = 1'b0;
      end
   endtask

   initial begin
      int         gap;
      int         kind;
      logic [5:0] dest;
      logic       go, stop;
      logic [7:0] b;
      int         guard;
      int         i;
      int         n;
      logic [7:0] v;

      rst = 1'b1;
      drive(1'b0, 1'b0, 6'h00);
      repeat (3) tick();

      // reset state
      chk("rst_tx", bus.TX, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.tx_done, 1'b0);
      chk("rst_pend", bus.pending, 1'b0);
      chk("rst_last", bus.last_cmd, 8'h00);
      rst = 1'b0;
      repeat (2) tick();

      // 1: go frame to station 0x15 -> 0x55
      req(1'b1, 1'b0, 6'h15);
      check_frame(8'h55, 1'b0, 1'b0);
      chk("t1_done", bus.tx_done, 1'b1);
      chk("t1_busy", bus.busy, 1'b0);
      chk("t1_tx", bus.TX, 1'b1);
      tick();
      chk("t1_done_once", bus.tx_done, 1'b0);
      chk("t1_last", bus.last_cmd, 8'h55);
      repeat (2) tick();

      // 2: stop beats go in the same cycle
      req(1'b1, 1'b1, 6'h3F);
      check_frame(8'h00, 1'b0, 1'b0);
      chk("t2_done", bus.tx_done, 1'b1);
      chk("t2_last", bus.last_cmd, 8'h00);
      repeat (2) tick();

      // 3: overwrite while busy, chained launch in the tx_done cycle
      req(1'b1, 1'b0, 6'h01);
      for (int k = 0; k < 10*B; k++) begin
         chk("t3_tx", bus.TX, frame_bit(8'h41, k / B));
         chk("t3_busy", bus.busy, 1'b1);
         chk("t3_pend", bus.pending, (k >= 10) ? 1'b1 : 1'b0);
         drive((k == 9) ? 1'b1 : 1'b0, (k == 19) ? 1'b1 : 1'b0, 6'h02);
         tick();
      end
      drive(1'b0, 1'b0, 6'h00);
      check_frame(8'h00, 1'b1, 1'b1);

      // 4: idle request exactly in the tx_done cycle
      chk("t4_done", bus.tx_done, 1'b1);
      chk("t4_busy", bus.busy, 1'b0);
      chk("t4_tx_gap", bus.TX, 1'b1);
      req(1'b1, 1'b0, 6'h0A);
      check_frame(8'h4A, 1'b0, 1'b0);
      chk("t4_done2", bus.tx_done, 1'b1);
      chk("t4_busy2", bus.busy, 1'b0);
      tick();
      chk("t4_done_clr", bus.tx_done, 1'b0);

      // 5: reset during data bit 3 with a request held
      req(1'b1, 1'b0, 6'h3F);
      repeat (4) tick();
      req(1'b1, 1'b0, 6'h11);
      repeat (12) tick();
      chk("t5_pre_pend", bus.pending, 1'b1);
      chk("t5_pre_last", bus.last_cmd, 8'h7F);
      rst = 1'b1;
      #1;
      chk("t5_tx", bus.TX, 1'b1);
      chk("t5_busy", bus.busy, 1'b0);
      chk("t5_pend", bus.pending, 1'b0);
      chk("t5_last", bus.last_cmd, 8'h00);
      chk("t5_done", bus.tx_done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      req(1'b0, 1'b1, 6'h00);
      check_frame(8'h00, 1'b0, 1'b0);
      chk("t5_done2", bus.tx_done, 1'b1);
      repeat (3) tick();

      // 6: random requests against the model
      m_done = cyc;
      tx_log.delete();
      done_cnt = 0;
      logging  = 1'b1;
      for (int r = 0; r < 50; r++) begin
         gap = $urandom_range(0, 60);
         for (int g = 0; g < gap; g++) begin
            model_step(cyc, 1'b0, 8'h00);
            tick();
         end
         kind = $urandom_range(0, 3);
         dest = 6'($urandom_range(0, 63));
         go   = (kind != 0);
         stop = (kind == 0) || (kind == 3);
         b    = stop ? 8'h00 : {2'b01, dest};
         drive(go, stop, dest);
         model_step(cyc, 1'b1, b);
         tick();
         drive(1'b0, 1'b0, 6'h00);
      end
      guard = 0;
      while (cyc < m_done + 3 && guard < 5000) begin
         model_step(cyc, 1'b0, 8'h00);
         tick();
         guard++;
      end
      chk("t6_drain", (guard < 5000) ? 1'b1 : 1'b0, 1'b1);
      logging = 1'b0;

      // UART decode of the logged line, mid-bit sampling
      i = 0;
      n = tx_log.size();
      while (i < n) begin
         if (tx_log[i] == 1'b0) begin
            chk("t6_fits", (i + 10*B <= n) ? 1'b1 : 1'b0, 1'b1);
            if (i + 10*B <= n) begin
               for (int k = 0; k < 8; k++) v[k] = tx_log[i + (k+1)*B + B/2];
               chk("t6_stopbit", tx_log[i + 9*B + B/2], 1'b1);
               dec_q.push_back(v);
            end
            i = i + 10*B;
         end else begin
            i++;
         end
      end
      chk("t6_nframes", dec_q.size(), exp_q.size());
      chk("t6_ndone", done_cnt, exp_q.size());
      for (int j = 0; j < exp_q.size() && j < dec_q.size(); j++) begin
         chk("t6_byte", dec_q[j], exp_q[j]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
